// File: rtl/load_store_unit.sv
// Load/store unit: steers pipeline byte/half/word accesses onto a
// word-wide valid/ready bus, extracts load data and aborts on timeout.
module load_store_unit #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic [2:0]  mem_read_type,
  input  logic [3:0]  mem_write_mask,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  output logic        busy,
  output logic        done,
  output logic [31:0] load_data,
  output logic        misaligned,
  output logic        bus_error,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_wstrb,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata,
  input  logic        bus_rvalid
);

  localparam logic [2:0] RT_BYTE = 3'd1;
  localparam logic [2:0] RT_HALF = 3'd2;
  localparam logic [2:0] RT_WORD = 3'd3;
  localparam logic [2:0] RT_BU   = 3'd4;
  localparam logic [2:0] RT_HU   = 3'd5;
  localparam int CW = 10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DONE
  } state_e;

  state_e        state_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_n;
  logic          tmo;
  logic          busy_q;
  logic          done_q;
  logic          mis_q;
  logic          err_q;
  logic          bv_q;
  logic          we_q;
  logic [31:0]   addr_q;
  logic [3:0]    wstrb_q;
  logic [31:0]   wdata_q;
  logic [31:0]   ld_q;
  logic [2:0]    rtype_q;
  logic [1:0]    alo_q;
  logic          hs_q;
  logic          rhit_q;
  logic [31:0]   rbuf_q;

  logic          rd_ok;
  logic          wr_ok;
  logic          mis_c;
  logic [3:0]    wstrb_c;
  logic [31:0]   wdata_c;
  logic [31:0]   rsrc;
  logic [7:0]    lb;
  logic [15:0]   lh;
  logic [31:0]   ld_c;

  always_comb begin
    rd_ok = (mem_read_type >= RT_BYTE) &&
            (mem_read_type <= RT_HU);
    wr_ok = (mem_write_mask == 4'b0001) ||
            (mem_write_mask == 4'b0011) ||
            (mem_write_mask == 4'b1111);
    mis_c = 1'b0;
    if (rd_ok) begin
      mis_c = ((mem_read_type == RT_HALF ||
                mem_read_type == RT_HU) && addr[0]) ||
              (mem_read_type == RT_WORD &&
               addr[1:0] != 2'b00);
    end else if (wr_ok) begin
      mis_c = (mem_write_mask == 4'b0011 && addr[0]) ||
              (mem_write_mask == 4'b1111 &&
               addr[1:0] != 2'b00);
    end
    wstrb_c = mem_write_mask << addr[1:0];
    unique case (1'b1)
      mem_write_mask == 4'b0001:
        wdata_c = {4{store_data[7:0]}};
      mem_write_mask == 4'b0011:
        wdata_c = {2{store_data[15:0]}};
      default:
        wdata_c = store_data;
    endcase
  end

  // Response may have been caught during the post-handshake REQ cycle.
  always_comb begin
    rsrc = rhit_q ? rbuf_q : bus_rdata;
    lb   = rsrc[{alo_q, 3'b000} +: 8];
    lh   = rsrc[{alo_q[1], 4'b0000} +: 16];
    unique case (rtype_q)
      RT_BYTE: ld_c = {{24{lb[7]}}, lb};
      RT_HALF: ld_c = {{16{lh[15]}}, lh};
      RT_BU:   ld_c = {24'b0, lb};
      RT_HU:   ld_c = {16'b0, lh};
      default: ld_c = rsrc;
    endcase
  end

  assign cnt_n = cnt_q + 1'b1;
  assign tmo   = (cnt_n == CW'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      mis_q   <= 1'b0;
      err_q   <= 1'b0;
      bv_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wstrb_q <= '0;
      wdata_q <= '0;
      ld_q    <= '0;
      rtype_q <= '0;
      alo_q   <= '0;
      hs_q    <= 1'b0;
      rhit_q  <= 1'b0;
      rbuf_q  <= '0;
    end else begin
      done_q <= 1'b0;
      mis_q  <= 1'b0;
      err_q  <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (req_valid && (rd_ok || wr_ok)) begin
            busy_q <= 1'b1;
            if (rd_ok && wr_ok) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else if (mis_c) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
              mis_q   <= 1'b1;
            end else begin
              state_q <= S_REQ;
              cnt_q   <= '0;
              bv_q    <= 1'b1;
              we_q    <= wr_ok;
              addr_q  <= {addr[31:2], 2'b00};
              wstrb_q <= wr_ok ? wstrb_c : 4'b0;
              wdata_q <= wr_ok ? wdata_c : 32'b0;
              rtype_q <= mem_read_type;
              alo_q   <= addr[1:0];
              hs_q    <= 1'b0;
              rhit_q  <= 1'b0;
            end
          end
        end
        // One settle cycle follows the handshake before moving on.
        S_REQ: begin
          cnt_q <= cnt_n;
          if (hs_q && we_q) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else if (tmo) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
            bv_q    <= 1'b0;
          end else if (hs_q) begin
            state_q <= S_WAIT;
            if (bus_rvalid) begin
              rhit_q <= 1'b1;
              rbuf_q <= bus_rdata;
            end
          end else if (bv_q && bus_ready) begin
            bv_q <= 1'b0;
            hs_q <= 1'b1;
          end
        end
        S_WAIT: begin
          cnt_q <= cnt_n;
          if (rhit_q || bus_rvalid) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            ld_q    <= ld_c;
          end else if (tmo) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
            err_q   <= 1'b1;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign load_data  = ld_q;
  assign misaligned = mis_q;
  assign bus_error  = err_q;
  assign bus_valid  = bv_q;
  assign bus_we     = we_q;
  assign bus_addr   = addr_q;
  assign bus_wstrb  = wstrb_q;
  assign bus_wdata  = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Randomised bench for load_store_unit: bus responder plus an
// access-size/lane model of alignment, steering and extension.
module tb_load_store_unit;

  localparam int T = 8;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic [2:0]  mem_read_type;
  logic [3:0]  mem_write_mask;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        busy;
  logic        done;
  logic [31:0] load_data;
  logic        misaligned;
  logic        bus_error;
  logic        bus_valid;
  logic        bus_ready;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_wstrb;
  logic [31:0] bus_wdata;
  logic [31:0] bus_rdata;
  logic        bus_rvalid;

  int          n_chk;
  int          n_err;
  logic [31:0] exp_ld;

  load_store_unit #(.TIMEOUT_CYCLES(T)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .mem_read_type  (mem_read_type),
    .mem_write_mask (mem_write_mask),
    .addr           (addr),
    .store_data     (store_data),
    .busy           (busy),
    .done           (done),
    .load_data      (load_data),
    .misaligned     (misaligned),
    .bus_error      (bus_error),
    .bus_valid      (bus_valid),
    .bus_ready      (bus_ready),
    .bus_we         (bus_we),
    .bus_addr       (bus_addr),
    .bus_wstrb      (bus_wstrb),
    .bus_wdata      (bus_wdata),
    .bus_rdata      (bus_rdata),
    .bus_rvalid     (bus_rvalid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, exp finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic run_op(input logic [2:0]  rt,
                        input logic [3:0]  wm,
                        input logic [31:0] a,
                        input logic [31:0] sd,
                        input int          d,
                        input int          r,
                        input logic [31:0] rd,
                        input bit          bogus,
                        input bit          no_ready,
                        input bit          no_rv);
    bit rd_ok, wr_ok, ign, ill, mis, tmo_exp, saw_v;
    int sz, off, lat, n, h, vcnt, got;
    logic [31:0] e_wd, v;
    logic [3:0]  e_st;
    rd_ok = (rt >= 3'd1 && rt <= 3'd5);
    wr_ok = (wm == 4'h1 || wm == 4'h3 || wm == 4'hF);
    ign   = !rd_ok && !wr_ok;
    ill   = rd_ok && wr_ok;
    if (rd_ok)
      sz = (rt == 3'd1 || rt == 3'd4) ? 1 : (rt == 3'd3) ? 4 : 2;
    else
      sz = (wm == 4'h1) ? 1 : (wm == 4'h3) ? 2 : 4;
    off = int'(a[1:0]);
    mis = !ign && !ill && ((off % sz) != 0);
    e_st = '0;
    e_wd = '0;
    for (int i = 0; i < 4; i++) begin
      if (i >= off && i < off + sz) e_st[i] = 1'b1;
      e_wd[8*i +: 8] = sd[8*(i % sz) +: 8];
    end
    v = rd;
    if (sz == 1) begin
      v = (rd >> (8 * off)) & 32'hFF;
      if (rt == 3'd1 && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2) begin
      v = (rd >> (8 * (off & 2))) & 32'hFFFF;
      if (rt == 3'd2 && v[15]) v = v | 32'hFFFF_0000;
    end
    tmo_exp = !ign && !ill && !mis &&
              (no_ready || (rd_ok && no_rv));
    if (ill || mis) lat = 1;
    else if (tmo_exp) lat = T + 1;
    else if (wr_ok) lat = 3 + d;
    else lat = 3 + d + ((r < 1) ? 1 : r);

    @(negedge clk);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);
    req_valid      = 1'b1;
    mem_read_type  = rt;
    mem_write_mask = wm;
    addr           = a;
    store_data     = sd;
    bus_ready      = 1'b0;
    bus_rvalid     = 1'b0;

    if (ign) begin
      for (int k = 0; k < 3; k++) begin
        @(negedge clk);
        req_valid = 1'b0;
        chk("ign_busy", 32'(busy), 32'd0);
        chk("ign_done", 32'(done), 32'd0);
      end
      return;
    end

    n = 0; h = -1; vcnt = 0; got = -1; saw_v = 1'b0;
    while (got < 0 && n < 40) begin
      @(negedge clk);
      n++;
      bus_ready      = 1'b0;
      bus_rvalid     = 1'b0;
      bus_rdata      = $urandom;
      req_valid      = 1'($urandom_range(0, 1));
      mem_read_type  = 3'($urandom_range(1, 5));
      mem_write_mask = 4'h0;
      addr           = $urandom & 32'hFFFF_FFFC;
      store_data     = $urandom;
      chk("busy", 32'(busy), 32'd1);
      if (done) begin
        got = n;
      end else begin
        if (h >= 0 && n == h + 1)
          chk("bv_drop", 32'(bus_valid), 32'd0);
        if (bus_valid) begin
          saw_v = 1'b1;
          chk("b_addr", bus_addr, {a[31:2], 2'b00});
          chk("b_we", 32'(bus_we), 32'(wr_ok));
          if (wr_ok) begin
            chk("b_wstrb", 32'(bus_wstrb), 32'(e_st));
            chk("b_wdata", bus_wdata, e_wd);
          end
          if (h < 0) begin
            if (!no_ready && vcnt >= d) begin
              bus_ready = 1'b1;
              h = n;
              if (bogus) begin
                bus_rvalid = 1'b1;
                bus_rdata  = ~rd;
              end
            end
            vcnt++;
          end
        end
        if (rd_ok && !no_rv && h >= 0 && n == h + 1 + r) begin
          bus_rvalid = 1'b1;
          bus_rdata  = rd;
        end
      end
    end
    chk("latency", 32'(got), 32'(lat));
    chk("mis", 32'(misaligned), 32'(mis));
    chk("berr", 32'(bus_error), 32'(ill || tmo_exp));
    chk("bv_done", 32'(bus_valid), 32'd0);
    chk("saw_bus", 32'(saw_v), 32'(!(ill || mis)));
    if (rd_ok && !ill && !mis && !tmo_exp) exp_ld = v;
    chk("ld", load_data, exp_ld);
  endtask

  logic [3:0] wm_tab [5];

  initial begin
    n_chk = 0;
    n_err = 0;
    exp_ld = '0;
    wm_tab[0] = 4'h0; wm_tab[1] = 4'h1; wm_tab[2] = 4'h3;
    wm_tab[3] = 4'hF; wm_tab[4] = 4'h0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    mem_read_type = '0;
    mem_write_mask = '0;
    addr = '0;
    store_data = '0;
    bus_ready = 1'b0;
    bus_rdata = '0;
    bus_rvalid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bv", 32'(bus_valid), 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_ld", load_data, 32'd0);
    rst_n = 1'b1;

    run_op(3'd0, 4'h1, 32'h1003, 32'hA5, 0, 0, 0, 0, 0, 0);
    run_op(3'd1, 4'h0, 32'h2002, 0, 0, 1, 32'h0080FF00, 1, 0, 0);
    run_op(3'd4, 4'h0, 32'h2002, 0, 0, 0, 32'h0080FF00, 0, 0, 0);
    run_op(3'd3, 4'h0, 32'h3002, 0, 0, 0, 0, 0, 0, 0);
    run_op(3'd0, 4'hF, 32'h7000, 32'hDEADBEEF, 5, 0, 0, 0, 0, 0);
    run_op(3'd2, 4'h0, 32'h5002, 0, 1, 2, 32'h80017FFF, 1, 0, 0);
    run_op(3'd5, 4'h0, 32'h5002, 0, 0, 1, 32'h80017FFF, 0, 0, 0);
    run_op(3'd3, 4'h3, 32'h6000, 32'h1, 0, 0, 0, 0, 0, 0);
    run_op(3'd6, 4'h3, 32'h6002, 32'h1234, 0, 0, 0, 0, 0, 0);
    run_op(3'd3, 4'h5, 32'h6004, 0, 2, 0, 32'hCAFEF00D, 0, 0, 0);
    run_op(3'd0, 4'h0, 32'h6008, 0, 0, 0, 0, 0, 0, 0);

    run_op(3'd2, 4'h0, 32'h5002, 0, 0, 0, 0, 0, 0, 1);
    @(negedge clk);
    req_valid  = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h5555AAAA;
    @(negedge clk);
    bus_rvalid = 1'b0;
    chk("late_done", 32'(done), 32'd0);
    chk("late_busy", 32'(busy), 32'd0);
    chk("late_ld", load_data, exp_ld);
    run_op(3'd0, 4'hF, 32'h6000, 32'h0BAD0BAD, 0, 0, 0, 0, 1, 0);

    @(negedge clk);
    chk("pre_busy", 32'(busy), 32'd0);
    req_valid = 1'b1;
    mem_read_type = 3'd3;
    mem_write_mask = 4'h0;
    addr = 32'h4000;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      req_valid = 1'b0;
      bus_ready = (n == 1) ? bus_valid : 1'b0;
    end
    chk("wait_busy", 32'(busy), 32'd1);
    chk("wait_bv", 32'(bus_valid), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("r_busy", 32'(busy), 32'd0);
    chk("r_done", 32'(done), 32'd0);
    chk("r_mis", 32'(misaligned), 32'd0);
    chk("r_err", 32'(bus_error), 32'd0);
    chk("r_bv", 32'(bus_valid), 32'd0);
    chk("r_we", 32'(bus_we), 32'd0);
    chk("r_wstrb", 32'(bus_wstrb), 32'd0);
    chk("r_addr", bus_addr, 32'd0);
    chk("r_wdata", bus_wdata, 32'd0);
    chk("r_ld", load_data, 32'd0);
    exp_ld = '0;
    rst_n = 1'b1;
    bus_rvalid = 1'b1;
    bus_rdata = 32'h12345678;
    @(negedge clk);
    bus_rvalid = 1'b0;
    chk("r_late_done", 32'(done), 32'd0);
    chk("r_late_ld", load_data, 32'd0);
    run_op(3'd0, 4'h1, 32'h1001, 32'h3C, 0, 0, 0, 0, 0, 0);

    for (int k = 0; k < 80; k++) begin
      logic [31:0] ra;
      ra = $urandom;
      if ($urandom_range(0, 1) == 0) ra[1:0] = 2'b00;
      run_op(3'($urandom_range(0, 7)),
             (k % 7 == 6) ? 4'($urandom) : wm_tab[$urandom_range(0, 4)],
             ra, $urandom,
             $urandom_range(0, 3), $urandom_range(0, 2),
             $urandom, 1'($urandom_range(0, 1)), 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255, SHALL set the maximum cycles spent in REQ+WAIT before an abort (range 1..1023).
REQ-002 clk  input  1  sole clock; all state SHALL change on its rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 req_valid  input  1  pipeline asks for a memory op this cycle.
REQ-005 mem_read_type  input  3  0 NONE, 1 BYTE, 2 HALF, 3 WORD, 4 B_U, 5 H_U; 6-7 SHALL be treated as NONE.
REQ-006 mem_write_mask  input  4  4'b0000 NONE, 4'b0001 BYTE, 4'b0011 HALF, 4'b1111 WORD; other values SHALL be treated as NONE.
REQ-007 addr  input  32  effective byte address from the ALU.
REQ-008 store_data  input  32  rs2 value, data right-aligned.
REQ-009 busy  output  1  high whenever state != IDLE; the pipeline stalls on it.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 load_data  output  32  extended load result, valid with done.
REQ-012 misaligned  output  1  valid with done; access rejected for alignment.
REQ-013 bus_error  output  1  valid with done; timeout or illegal request.
REQ-014 bus_valid / bus_ready  output / input  1 / 1  request handshake.
REQ-015 bus_we  output  1  1 = write.
REQ-016 bus_addr  output  32  word address, bits [1:0] SHALL be 2'b00.
REQ-017 bus_wstrb  output  4  byte-lane write enables.
REQ-018 bus_wdata  output  32  lane-replicated store data.
REQ-019 bus_rdata / bus_rvalid  input / input  32 / 1  read response.

Function
REQ-020 FSM states SHALL be IDLE, REQ, WAIT, DONE.
REQ-021 IDLE: req_valid with both types NONE SHALL be ignored; the state SHALL stay IDLE with no done.
REQ-022 IDLE: req_valid with read and write both non-NONE SHALL go to DONE with bus_error=1 and no bus access.
REQ-023 IDLE: a misaligned request SHALL go to DONE with misaligned=1 and no bus access. Misaligned means HALF/H_U/HALF-store with addr[0]=1, or WORD with addr[1:0]!=0.
REQ-024 IDLE: a legal request SHALL latch addr, type, mask and store_data and go to REQ; bus_valid SHALL rise on the next cycle.
REQ-025 REQ: bus_valid, bus_we, bus_addr, bus_wstrb and bus_wdata SHALL be held stable until bus_valid&bus_ready.
REQ-026 On the REQ handshake, a write SHALL go to DONE and a read SHALL go to WAIT; bus_valid SHALL drop in the following cycle.
REQ-027 WAIT: on bus_rvalid, bus_rdata SHALL be captured and extracted, and the state SHALL go to DONE. A bus_rvalid arriving in the same cycle as the handshake SHALL be ignored.
REQ-028 DONE: done=1 for exactly one cycle, then the state SHALL return to IDLE. req_valid SHALL be ignored in REQ/WAIT/DONE, so a new request is accepted at the earliest on the cycle after DONE.
REQ-029 Write lanes: bus_wstrb SHALL equal mask << addr[1:0]. bus_wdata SHALL be the byte replicated x4 for BYTE, the half replicated x2 for HALF, and store_data for WORD.
REQ-030 Read extraction: byte = rdata[8*addr[1:0] +: 8] and half = rdata[16*addr[1] +: 16]. BYTE/HALF SHALL be sign-extended and B_U/H_U zero-extended to 32 bits.
REQ-031 load_data SHALL update only on a completing read and hold otherwise; stores, errors and misalignment SHALL leave it unchanged.
REQ-032 Timeout counter:
- clears on entry to REQ;
- increments each cycle in REQ/WAIT;
- on reaching TIMEOUT_CYCLES, goes to DONE with bus_error=1 and drops bus_valid;
- a late bus_rvalid SHALL then be ignored.
REQ-033 Minimum latency, req_valid to done: store with bus_ready already high = 3 cycles; load with rvalid one cycle after the handshake = 4 cycles.

Reset
REQ-034 rst_n=0 at a clock edge SHALL force IDLE and counter=0, and set busy, done, misaligned, bus_error, bus_valid, bus_we, bus_wstrb, bus_addr, bus_wdata and load_data to 0.
REQ-035 Reset during REQ or WAIT SHALL abandon the transaction, drop bus_valid at that edge, produce no done, and ignore any later bus_rvalid.

Verification
REQ-036 SB: addr=0x1003, store_data=0x000000A5 -> bus_addr=0x1000, bus_wstrb=4'b1000, bus_wdata=0xA5A5A5A5; done once, load_data unchanged.
REQ-037 LB then LBU: addr=0x2002, rdata=0x0080FF00 -> load_data=0xFFFFFF80, then 0x00000080.
REQ-038 LW at addr=0x3002 -> done after 1 cycle, misaligned=1, bus_valid never high.
REQ-039 SW with bus_ready low 5 cycles -> bus_* signals stable for all 5 cycles; done 2 cycles after ready rises; busy high throughout.
REQ-040 LH with rvalid never asserted, TIMEOUT_CYCLES=8 -> bus_error=1 with done, busy low next cycle; a later rvalid has no effect.
REQ-041 LW with rst_n=0 in WAIT -> all outputs 0 next edge, no done; a new SB after reset completes normally.
